// File: rtl/tick_rate_gen_if.sv
// Control/status bundle between the board switches/button and the tick generator.
// The master drives the raw inputs, and the slave (the generator) returns the tick and its status.
interface tick_rate_gen_if;
  logic [1:0] speed_sel;
  logic       run;
  logic       step_n;
  logic       tick;
  logic       running;
  logic [1:0] sel_active;

  modport master (
    output speed_sel, run, step_n,
    input  tick, running, sel_active
  );

  modport slave (
    input  speed_sel, run, step_n,
    output tick, running, sel_active
  );
endinterface

// File: rtl/tick_rate_gen.sv
// Selectable-rate enable pulse generator with run/pause and a debounced single-step button.
// Drives the E input of the BCD digit counter.
module tick_rate_gen #(
  parameter int CLK_HZ       = 50000000,
  parameter int CNT_W        = 28,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input logic            clk,
  input logic            resetn,
  tick_rate_gen_if.slave bus
);
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  // The terminal counts are computed in 64 bits, so 4*CLK_HZ cannot wrap before the cast.
  localparam logic [CNT_W-1:0] TC_1 = CNT_W'(longint'(CLK_HZ) - 1);
  localparam logic [CNT_W-1:0] TC_2 = CNT_W'(2 * longint'(CLK_HZ) - 1);
  localparam logic [CNT_W-1:0] TC_4 = CNT_W'(4 * longint'(CLK_HZ) - 1);

  logic [1:0]       sel_s1, sel_s2, sel_q;
  logic             run_s1, run_s2;
  logic             step_s1, step_s2, step_db, step_db_d;
  logic [DB_W-1:0]  db_cnt;
  logic [CNT_W-1:0] cnt, tc;
  logic             tick_q;
  logic             rate_chg, step_fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_s1  <= 2'b01;
      sel_s2  <= 2'b01;
      run_s1  <= 1'b0;
      run_s2  <= 1'b0;
      step_s1 <= 1'b1;
      step_s2 <= 1'b1;
    end else begin
      sel_s1  <= bus.speed_sel;
      sel_s2  <= sel_s1;
      run_s1  <= bus.run;
      run_s2  <= run_s1;
      step_s1 <= bus.step_n;
      step_s2 <= step_s1;
    end
  end

  // The level flips only after DEBOUNCE_CYC consecutive mismatching samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_db   <= 1'b1;
      step_db_d <= 1'b1;
      db_cnt    <= '0;
    end else begin
      step_db_d <= step_db;
      if (step_s2 == step_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        step_db <= step_s2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    tc = '0;
    case (sel_q)
      2'b00:   tc = '0;
      2'b01:   tc = TC_1;
      2'b10:   tc = TC_2;
      default: tc = TC_4;
    endcase
  end

  assign rate_chg  = (sel_s2 != sel_q);
  assign step_fire = step_db_d & ~step_db & ~run_s2;

  // A rate change wins over both tick sources. The step path never touches cnt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q  <= 2'b01;
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (rate_chg) begin
      sel_q  <= sel_s2;
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (run_s2) begin
      if (cnt == tc) begin
        cnt    <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt    <= cnt + 1'b1;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= step_fire;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.running    = run_s2;
  assign bus.sel_active = sel_q;
endmodule

// File: tb/tb_tick_rate_gen.sv
// Directed bench for tick_rate_gen (CLK_HZ=10, DEBOUNCE_CYC=4). Expected tick cycles are
// queued by the stimulus, and a negedge monitor pops one entry per observed tick.
module tb_tick_rate_gen;
  logic clk, resetn;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   exp_q[$];
  int   e, f, g, h, k, m, n, s, t;

  tick_rate_gen_if bus();

  tick_rate_gen #(.CLK_HZ(10), .CNT_W(8), .DEBOUNCE_CYC(4)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tick) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick got tick at cyc %0d want none queued", cyc);
      end else begin
        int want;
        want = exp_q.pop_front();
        if (want != cyc) begin
          n_fail++;
          $display("FAIL tick_time got cyc %0d want cyc %0d", cyc, want);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn        = 1'b0;
    bus.speed_sel = 2'b01;
    bus.run       = 1'b1;
    bus.step_n    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_sel", int'(bus.sel_active), 1);

    // 1: 1 Hz free-run after reset release
    e = cyc; resetn = 1'b1;
    exp_q.push_back(e + 12); exp_q.push_back(e + 22); exp_q.push_back(e + 32);
    goto(e + 35);
    chk("s1_running", int'(bus.running), 1);
    chk("s1_sel", int'(bus.sel_active), 1);

    // 2: 0.25 Hz, then full rate, then back to 1 Hz
    f = cyc; bus.speed_sel = 2'b11;
    exp_q.push_back(f + 43); exp_q.push_back(f + 83);
    goto(f + 4);
    chk("s2_sel11", int'(bus.sel_active), 3);
    goto(f + 85);
    g = cyc; bus.speed_sel = 2'b00;
    for (int i = 4; i <= 13; i++) exp_q.push_back(g + i);
    goto(g + 6);
    chk("s2_sel00", int'(bus.sel_active), 0);
    goto(g + 11);
    h = cyc; bus.speed_sel = 2'b01;

    // 3: pause with cnt=6, resume
    goto(h + 7); bus.run = 1'b0;
    goto(h + 30);
    chk("s3_paused", int'(bus.running), 0);
    k = cyc; bus.run = 1'b1;
    exp_q.push_back(k + 6);
    goto(k + 6); bus.run = 1'b0;

    // 4: bounces, then two clean presses while paused
    goto(k + 10);
    m = cyc; bus.step_n = 1'b0;
    goto(m + 2); bus.step_n = 1'b1;
    goto(m + 4); bus.step_n = 1'b0;
    goto(m + 6); bus.step_n = 1'b1;
    goto(m + 10);
    n = cyc; bus.step_n = 1'b0; exp_q.push_back(n + 7);
    goto(n + 10); bus.step_n = 1'b1;
    goto(n + 16); bus.step_n = 1'b0; exp_q.push_back(n + 23);
    goto(n + 30); bus.step_n = 1'b1;

    // 5: press while running is discarded
    goto(n + 40);
    s = cyc; bus.run = 1'b1;
    exp_q.push_back(s + 10); exp_q.push_back(s + 20);
    goto(s + 12); bus.step_n = 1'b0;
    goto(s + 22); bus.step_n = 1'b1;

    // 6: asynchronous reset while tick is high
    goto(s + 30);
    chk("s6_tick_pre", int'(bus.tick), 1);
    resetn = 1'b0;
    #1;
    chk("s6_tick_rst", int'(bus.tick), 0);
    chk("s6_running_rst", int'(bus.running), 0);
    chk("s6_sel_rst", int'(bus.sel_active), 1);
    repeat (3) @(posedge clk);
    #1;
    t = cyc; resetn = 1'b1;
    exp_q.push_back(t + 12); exp_q.push_back(t + 22);
    goto(t + 25);
    chk("s6_running", int'(bus.running), 1);
    chk("s6_sel", int'(bus.sel_active), 1);
    chk("pending_ticks", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
